// File: rtl/bist_pkg.sv
// Shared types and the deterministic test-data generator for the BIST pattern checker.
// The checker top optionally builds an error log when BIST_ERRLOG_EN is defined.
package bist_pkg;

   localparam int                CNT_W     = 10;
   localparam logic [CNT_W-1:0]  DEPTH_DEF = 10'h200;
   localparam int                PAT_MAX_W = 64;

   typedef enum logic [1:0] {
      PAT_INDEX   = 2'b00,
      PAT_CHECKER = 2'b01,
      PAT_INVERT  = 2'b10,
      PAT_WALK    = 2'b11
   } pattern_sel_t;

   typedef enum logic [1:0] {
      CHK_IDLE = 2'b00,
      CHK_RUN  = 2'b01,
      CHK_DONE = 2'b10
   } chk_state_t;

   typedef struct packed {
      chk_state_t       state;
      logic [CNT_W-1:0] cmp_cnt;
   } chk_dbg_t;

   // Result is PAT_MAX_W wide; callers cast down to their data width (<= PAT_MAX_W).
   function automatic logic [PAT_MAX_W-1:0] pattern_gen(input pattern_sel_t sel,
                                                        input logic [CNT_W-1:0] idx,
                                                        input int data_w);
      logic [PAT_MAX_W-1:0] ext;
      ext = {{(PAT_MAX_W-CNT_W){1'b0}}, idx};
      case (sel)
         PAT_INDEX:   return ext;
         PAT_CHECKER: return idx[0] ? {(PAT_MAX_W/8){8'hAA}} : {(PAT_MAX_W/8){8'h55}};
         PAT_INVERT:  return ~ext;
         default:     return PAT_MAX_W'(1) << (int'(idx) % data_w);
      endcase
   endfunction

endpackage

// File: rtl/bist_rd_pipe.sv
// RD_LAT-deep shift pipeline carrying {valid, idx} compare tokens so each
// token emerges in the cycle its FIFO read data is valid.
module bist_rd_pipe #(
   parameter int RD_LAT = 1,
   parameter int IDX_W  = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             IN_VLD,
   input  logic [IDX_W-1:0] IN_IDX,
   output logic             OUT_VLD,
   output logic [IDX_W-1:0] OUT_IDX
);

   logic [RD_LAT-1:0] vld_q;
   logic [IDX_W-1:0]  idx_q [RD_LAT];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
      end else if (CLR) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
      end else begin
         vld_q[0] <= IN_VLD;
         idx_q[0] <= IN_IDX;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   assign OUT_VLD = vld_q[RD_LAT-1];
   assign OUT_IDX = idx_q[RD_LAT-1];

endmodule

// File: rtl/bist_pattern_checker.sv
// BIST datapath: sequences write/read counts, drives pattern data to the FIFO and
// checks read data. Define BIST_ERRLOG_EN to add first-miscompare capture ports.
module bist_pattern_checker
   import bist_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              BIST_EN,
   input  logic [1:0]        PATTERN_SEL,
   input  logic              W_EN,
   input  logic              R_EN,
   input  logic [DATA_W-1:0] FIFO_DOUT,
   output logic [CNT_W-1:0]  WRITE_CNT,
   output logic [CNT_W-1:0]  READ_CNT,
   output logic [DATA_W-1:0] FIFO_DIN,
   output logic              BIST_DONE,
   output logic              BIST_FAIL,
   output logic [7:0]        ERR_CNT,
`ifdef BIST_ERRLOG_EN
   output logic [CNT_W-1:0]  ERR_ADDR,
   output logic [DATA_W-1:0] ERR_EXP,
   output logic [DATA_W-1:0] ERR_ACT,
`endif
   output chk_dbg_t          CHK_DBG
);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

   // W_EN/R_EN are one-cycle strobes with no back-pressure: a strobe is accepted
   // on the edge it is sampled high only while its count is below DEPTH, else dropped.
   pattern_sel_t     sel;
   logic             wr_acc;
   logic             rd_acc;
   logic             tok_vld;
   logic [CNT_W-1:0] tok_idx;
   logic [DATA_W-1:0] exp_data;
   logic             miscmp;
   chk_state_t       chk_state;
   logic [CNT_W-1:0] cmp_cnt;

   assign sel    = pattern_sel_t'(PATTERN_SEL);
   assign wr_acc = W_EN && (WRITE_CNT < DEPTH_C);
   assign rd_acc = R_EN && (READ_CNT < DEPTH_C);

   assign FIFO_DIN = DATA_W'(pattern_gen(sel, WRITE_CNT, DATA_W));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         WRITE_CNT <= '0;
         READ_CNT  <= '0;
      end else if (!BIST_EN) begin
         WRITE_CNT <= '0;
         READ_CNT  <= '0;
      end else begin
         if (wr_acc) WRITE_CNT <= WRITE_CNT + 1'b1;
         if (rd_acc) READ_CNT  <= READ_CNT + 1'b1;
      end
   end

   bist_rd_pipe #(
      .RD_LAT (RD_LAT),
      .IDX_W  (CNT_W)
   ) u_rd_pipe (
      .CLK     (CLK),
      .RST     (RST),
      .CLR     (!BIST_EN),
      .IN_VLD  (rd_acc),
      .IN_IDX  (READ_CNT),
      .OUT_VLD (tok_vld),
      .OUT_IDX (tok_idx)
   );

   // Tokens are only honoured in CHK_RUN; a stray token in CHK_DONE is ignored.
   assign exp_data = DATA_W'(pattern_gen(sel, tok_idx, DATA_W));
   assign miscmp   = tok_vld && (chk_state == CHK_RUN) && (FIFO_DOUT != exp_data);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         chk_state <= CHK_IDLE;
         cmp_cnt   <= '0;
         BIST_FAIL <= 1'b0;
         ERR_CNT   <= '0;
         BIST_DONE <= 1'b0;
      end else if (!BIST_EN) begin
         chk_state <= CHK_IDLE;
         cmp_cnt   <= '0;
         BIST_FAIL <= 1'b0;
         ERR_CNT   <= '0;
         BIST_DONE <= 1'b0;
      end else begin
         BIST_DONE <= (chk_state == CHK_DONE);
         case (chk_state)
            CHK_IDLE: begin
               if (rd_acc) chk_state <= CHK_RUN;
            end
            CHK_RUN: begin
               if (tok_vld) begin
                  cmp_cnt <= cmp_cnt + 1'b1;
                  if (miscmp) begin
                     BIST_FAIL <= 1'b1;
                     if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
                  end
                  if (tok_idx == LAST_IDX) chk_state <= CHK_DONE;
               end
            end
            CHK_DONE: chk_state <= CHK_DONE;
            default:  chk_state <= CHK_IDLE;
         endcase
      end
   end

   assign CHK_DBG = '{state: chk_state, cmp_cnt: cmp_cnt};

`ifdef BIST_ERRLOG_EN
   // BIST_FAIL still low means this miscompare is the first of the pass.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ERR_ADDR <= '0;
         ERR_EXP  <= '0;
         ERR_ACT  <= '0;
      end else if (!BIST_EN) begin
         ERR_ADDR <= '0;
         ERR_EXP  <= '0;
         ERR_ACT  <= '0;
      end else if (miscmp && !BIST_FAIL) begin
         ERR_ADDR <= tok_idx;
         ERR_EXP  <= exp_data;
         ERR_ACT  <= FIFO_DOUT;
      end
   end
`endif

endmodule

// File: tb/tb_bist_pattern_checker.sv
// Directed bench for bist_pattern_checker: stimulus pushes expectations tagged
// with the clock edge they apply after; a negedge monitor pops and compares.
module tb_bist_pattern_checker;
   import bist_pkg::*;

   localparam int S_WCNT  = 0;
   localparam int S_RCNT  = 1;
   localparam int S_DIN   = 2;
   localparam int S_DONE  = 3;
   localparam int S_FAIL  = 4;
   localparam int S_ERR   = 5;
   localparam int S_STATE = 6;
   localparam int S_CMP   = 7;
   localparam int S_EADDR = 8;
   localparam int S_EEXP  = 9;
   localparam int S_EACT  = 10;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       BIST_EN = 1'b0;
   logic [1:0] PATTERN_SEL = 2'b00;
   logic       W_EN = 1'b0;
   logic       R_EN = 1'b0;
   logic [7:0] FIFO_DOUT = 8'h00;

   logic [9:0] write_cnt, read_cnt;
   logic [7:0] fifo_din, err_cnt;
   logic       bist_done, bist_fail;
   chk_dbg_t   chk_dbg;
`ifdef BIST_ERRLOG_EN
   logic [9:0] err_addr;
   logic [7:0] err_exp, err_act;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   logic [15:0] exp_q[$];
   int          sig_q[$];
   int          at_q[$];

   logic [1:0] rd_sel = 2'b00;
   int         rd_bad = -1;
   logic [7:0] rd_badv = 8'h00;
   bit         rd_stuck = 1'b0;
   int         err_model = 0;

   bist_pattern_checker #(.DATA_W(8), .DEPTH(512), .RD_LAT(1)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .BIST_EN     (BIST_EN),
      .PATTERN_SEL (PATTERN_SEL),
      .W_EN        (W_EN),
      .R_EN        (R_EN),
      .FIFO_DOUT   (FIFO_DOUT),
      .WRITE_CNT   (write_cnt),
      .READ_CNT    (read_cnt),
      .FIFO_DIN    (fifo_din),
      .BIST_DONE   (bist_done),
      .BIST_FAIL   (bist_fail),
      .ERR_CNT     (err_cnt),
`ifdef BIST_ERRLOG_EN
      .ERR_ADDR    (err_addr),
      .ERR_EXP     (err_exp),
      .ERR_ACT     (err_act),
`endif
      .CHK_DBG     (chk_dbg)
   );

   // ---------------- clock / edge counter ----------------
   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_n <= edge_n + 1;

   // ---------------- reference model ----------------
   function automatic logic [7:0] model_p(input logic [1:0] sel, input int k);
      logic [9:0] ii;
      ii = (k > 512) ? 10'd512 : 10'(k);
      case (sel)
         2'b00:   return ii[7:0];
         2'b01:   return ii[0] ? 8'hAA : 8'h55;
         2'b10:   return ~ii[7:0];
         default: return 8'h01 << ii[2:0];
      endcase
   endfunction

   function automatic logic [7:0] fifo_word(input int k);
      if (rd_stuck) return 8'h00;
      if (k == rd_bad) return rd_badv;
      return model_p(rd_sel, k);
   endfunction

   // ---------------- scoreboard ----------------
   function automatic string sig_name(input int s);
      case (s)
         S_WCNT:  return "WRITE_CNT";
         S_RCNT:  return "READ_CNT";
         S_DIN:   return "FIFO_DIN";
         S_DONE:  return "BIST_DONE";
         S_FAIL:  return "BIST_FAIL";
         S_ERR:   return "ERR_CNT";
         S_STATE: return "CHK_STATE";
         S_CMP:   return "CMP_CNT";
         S_EADDR: return "ERR_ADDR";
         S_EEXP:  return "ERR_EXP";
         default: return "ERR_ACT";
      endcase
   endfunction

   function automatic logic [15:0] get_sig(input int s);
      case (s)
         S_WCNT:  return {6'b0, write_cnt};
         S_RCNT:  return {6'b0, read_cnt};
         S_DIN:   return {8'b0, fifo_din};
         S_DONE:  return {15'b0, bist_done};
         S_FAIL:  return {15'b0, bist_fail};
         S_ERR:   return {8'b0, err_cnt};
         S_STATE: return {14'b0, chk_dbg.state};
         S_CMP:   return {6'b0, chk_dbg.cmp_cnt};
`ifdef BIST_ERRLOG_EN
         S_EADDR: return {6'b0, err_addr};
         S_EEXP:  return {8'b0, err_exp};
         S_EACT:  return {8'b0, err_act};
`endif
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic expect_at(input int s, input logic [15:0] v, input int at);
      sig_q.push_back(s);
      exp_q.push_back(v);
      at_q.push_back(at);
   endtask

   task automatic expect_now(input int s, input logic [15:0] v);
      expect_at(s, v, edge_n);
   endtask

   task automatic check_sig(input int s, input logic [15:0] exp);
      logic [15:0] act;
      act = get_sig(s);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s after edge %0d: got %h expected %h", sig_name(s), edge_n, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      while (at_q.size() > 0 && at_q[0] <= edge_n) begin
         int s;
         logic [15:0] v;
         s = sig_q.pop_front();
         v = exp_q.pop_front();
         void'(at_q.pop_front());
         check_sig(s, v);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_bist(input logic [1:0] sel);
      @(posedge CLK); #1;
      BIST_EN = 1'b0; W_EN = 1'b0; R_EN = 1'b0; FIFO_DOUT = 8'h00;
      PATTERN_SEL = sel;
      @(posedge CLK); #1;
      expect_now(S_WCNT, 16'd0);
      expect_now(S_RCNT, 16'd0);
      expect_now(S_DONE, 16'd0);
      expect_now(S_FAIL, 16'd0);
      expect_now(S_ERR, 16'd0);
      expect_now(S_STATE, 16'd0);
      expect_now(S_DIN, {8'b0, model_p(sel, 0)});
      BIST_EN = 1'b1;
      rd_sel = sel; rd_bad = -1; rd_badv = 8'h00; rd_stuck = 1'b0; err_model = 0;
   endtask

   task automatic write_pass(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK); #1;
         W_EN = 1'b1;
         expect_now(S_WCNT, 16'((k > 512) ? 512 : k));
         expect_now(S_DIN, {8'b0, model_p(PATTERN_SEL, k)});
      end
      @(posedge CLK); #1;
      W_EN = 1'b0;
      expect_now(S_WCNT, 16'((n > 512) ? 512 : n));
      expect_now(S_DIN, {8'b0, model_p(PATTERN_SEL, n)});
   endtask

   task automatic note_compare(input int j);
      if (fifo_word(j) != model_p(rd_sel, j)) begin
         if (err_model == 0) expect_now(S_FAIL, 16'd0);
         if (err_model < 255) err_model++;
         expect_at(S_FAIL, 16'd1, edge_n + 1);
         expect_at(S_ERR, 16'(err_model), edge_n + 1);
      end
   endtask

   task automatic read_pass(input int n, input bit finish);
      int last;
      for (int k = 0; k < n; k++) begin
         @(posedge CLK); #1;
         R_EN = 1'b1;
         expect_now(S_RCNT, 16'(k));
         if (k > 0) begin
            FIFO_DOUT = fifo_word(k - 1);
            note_compare(k - 1);
         end
      end
      if (finish) begin
         @(posedge CLK); #1;
         R_EN = 1'b0;
         last = edge_n;
         expect_now(S_RCNT, 16'd512);
         FIFO_DOUT = fifo_word(511);
         note_compare(511);
         expect_at(S_DONE, 16'd0, last + 1);
         expect_at(S_DONE, 16'd1, last + 2);
         expect_at(S_STATE, {14'b0, CHK_DONE}, last + 2);
         expect_at(S_CMP, 16'd512, last + 2);
         expect_at(S_FAIL, 16'(err_model != 0), last + 2);
         expect_at(S_ERR, 16'(err_model), last + 2);
         repeat (2) @(posedge CLK);
         #1;
         FIFO_DOUT = 8'h00;
         R_EN = 1'b1;
         @(posedge CLK); #1;
         R_EN = 1'b0;
         expect_now(S_RCNT, 16'd512);
         expect_now(S_DONE, 16'd1);
      end
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      summary();
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      // reset state while RST is held low
      repeat (2) @(posedge CLK);
      #1;
      expect_now(S_WCNT, 16'd0);
      expect_now(S_RCNT, 16'd0);
      expect_now(S_DIN, 16'h0000);
      expect_now(S_DONE, 16'd0);
      expect_now(S_FAIL, 16'd0);
      expect_now(S_ERR, 16'd0);
      @(negedge CLK); #1;
      RST = 1'b1;

      // index pattern, clean full pass
      clear_bist(2'b00);
      write_pass(512);
      read_pass(512, 1'b1);

      // checkerboard with read idx 7 corrupted
      clear_bist(2'b01);
      write_pass(512);
      rd_bad = 7; rd_badv = 8'h00;
      read_pass(512, 1'b1);

      // write overrun saturates at DEPTH
      clear_bist(2'b00);
      write_pass(600);

      // abort at READ_CNT=100 after an injected error, then a clean pass
      clear_bist(2'b00);
      write_pass(512);
      rd_bad = 50; rd_badv = 8'hFF;
      read_pass(100, 1'b0);
      @(posedge CLK); #1;
      R_EN = 1'b0;
      BIST_EN = 1'b0;
      FIFO_DOUT = fifo_word(99);
      expect_now(S_RCNT, 16'd100);
      expect_now(S_FAIL, 16'd1);
      @(posedge CLK); #1;
      expect_now(S_WCNT, 16'd0);
      expect_now(S_RCNT, 16'd0);
      expect_now(S_DONE, 16'd0);
      expect_now(S_FAIL, 16'd0);
      expect_now(S_ERR, 16'd0);
      clear_bist(2'b00);
      write_pass(512);
      read_pass(512, 1'b1);

      // asynchronous reset mid-write, between clock edges
      clear_bist(2'b00);
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         W_EN = 1'b1;
         if (k == 19) expect_now(S_WCNT, 16'd19);
      end
      @(posedge CLK); #2;
      RST = 1'b0;
      expect_now(S_WCNT, 16'd0);
      expect_now(S_DIN, 16'h0000);
      expect_now(S_STATE, 16'd0);
      @(negedge CLK); #1;
      RST = 1'b1;
      W_EN = 1'b0;
      @(posedge CLK); #1;
      expect_now(S_WCNT, 16'd0);

      // walking one with read data stuck at zero: error count saturates
      clear_bist(2'b11);
      write_pass(512);
      rd_stuck = 1'b1;
      read_pass(512, 1'b1);
`ifdef BIST_ERRLOG_EN
      expect_now(S_EADDR, 16'd0);
      expect_now(S_EEXP, 16'h0001);
      expect_now(S_EACT, 16'h0000);
`endif

      // drain the scoreboard
      repeat (4) @(posedge CLK);
      #1;
      if (at_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", at_q.size());
      end
      summary();
      $finish;
   end

endmodule

// File: doc/bist_pattern_checker.md
Name: bist_pattern_checker

Overview:
BIST datapath companion to the BIST read/write-enable controller.
- Consumes that controller's W_EN/R_EN.
- Produces the WRITE_CNT/READ_CNT it sequences on.
- Drives deterministic test data into the FIFO write port.
- Checks FIFO read data against the expected pattern and reports done/pass/fail.

Parameters:
DATA_W, 8, FIFO data width in bits
DEPTH, 512, words per BIST pass; counters terminate at this value (10'h200)
RD_LAT, 1, cycles from R_EN sample to FIFO_DOUT valid (1..3)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
BIST_EN  in  1  BIST mode; low synchronously clears all state
PATTERN_SEL  in  2  00 index, 01 checkerboard, 10 inverted index, 11 walking one
W_EN  in  1  write enable from the BIST controller
R_EN  in  1  read enable from the BIST controller
FIFO_DOUT  in  DATA_W  FIFO read data
WRITE_CNT  out  10  writes issued this pass
READ_CNT  out  10  reads issued this pass
FIFO_DIN  out  DATA_W  write data for the current write
BIST_DONE  out  1  all DEPTH reads compared; sticky
BIST_FAIL  out  1  at least one miscompare; sticky
ERR_CNT  out  8  miscompare count, saturates at 8'hFF

Behaviour:
- Reset (RST low, asynchronous) sets every register to 0: counters, pipeline, checker state, BIST_DONE, BIST_FAIL, ERR_CNT. FIFO_DIN becomes pattern(0).
- BIST_EN low has the same clearing effect, synchronously on the next edge. PATTERN_SEL is sampled continuously and must stay stable while BIST_EN is high.
- Pattern function p(i), where i is the 10-bit index truncated/zero-extended to DATA_W:
  - 00: i
  - 01: 0x55.. when i even, 0xAA.. when i odd
  - 10: ~i
  - 11: 1 << (i mod DATA_W)
- Write side:
  - FIFO_DIN = p(WRITE_CNT), combinational from the register; no added latency.
  - On an edge with W_EN=1 and WRITE_CNT<DEPTH, WRITE_CNT increments.
  - At DEPTH the count holds and further W_EN is ignored.
- Read side:
  - On an edge with R_EN=1 and READ_CNT<DEPTH, READ_CNT increments and a compare token {valid, idx=READ_CNT} enters an RD_LAT-deep shift pipeline.
  - R_EN at READ_CNT==DEPTH issues no token.
- Compare: when a token exits the pipeline, FIFO_DOUT is compared with p(idx) in that cycle.
  - On mismatch, on the next edge: BIST_FAIL sets and ERR_CNT increments (saturating).
  - Compare count increments per token.
- Checker FSM, states CHK_IDLE, CHK_RUN, CHK_DONE:
  - CHK_IDLE to CHK_RUN on the first R_EN accepted.
  - CHK_RUN to CHK_DONE on the edge that consumes token idx==DEPTH-1.
  - CHK_DONE holds until BIST_EN drops, then returns to CHK_IDLE.
  - BIST_DONE = (state==CHK_DONE), registered. It asserts RD_LAT+1 edges after the last R_EN edge.
- Simultaneous W_EN and R_EN: both sides advance independently. This is legal but never produced by the controller.
- Reset or BIST_EN drop mid-pass aborts it. No partial result is retained; pipeline tokens are discarded.
- Tokens exiting while in CHK_DONE cannot occur. If seen, ignore them.

Optional Feature:
BIST_ERRLOG_EN
- Defined: adds outputs ERR_ADDR[9:0], ERR_EXP[DATA_W-1:0], ERR_ACT[DATA_W-1:0].
  - They capture idx, expected and actual data of the first miscompare only.
  - They clear on reset or BIST_EN low.
- Not defined: ports and capture logic are absent. All other behaviour is identical.

Decomposition:
Package bist_pkg holds:
- CNT_W=10 and DEPTH_DEF=10'h200
- typedef pattern_sel_t enum {PAT_INDEX, PAT_CHECKER, PAT_INVERT, PAT_WALK}
- typedef chk_state_t {CHK_IDLE, CHK_RUN, CHK_DONE}
- function pattern_gen(sel, idx)

One sub-module, bist_rd_pipe, is natural: the RD_LAT-deep valid/idx shift pipeline.

Test Plan:
- PAT_INDEX, full pass:
  - Drive W_EN 512 cycles. WRITE_CNT ends at 10'h200; FIFO_DIN ran 0x00..0xFF twice.
  - Drive R_EN 512 cycles with a correct FIFO model. BIST_DONE=1 RD_LAT+1 edges after the last R_EN; BIST_FAIL=0; ERR_CNT=0.
- Fault injection, PAT_CHECKER: corrupt read idx 7 to 0x00 (expected 0xAA). BIST_FAIL sets on the edge after the compare; ERR_CNT=1; BIST_DONE still asserts at end.
- Overrun: hold W_EN high 600 cycles. WRITE_CNT saturates at 10'h200 and FIFO_DIN holds p(512) = 0x00 for PAT_INDEX.
- Abort: drop BIST_EN at READ_CNT=100. On the next edge all counters are 0, BIST_DONE=0, BIST_FAIL=0. Re-enable and run a clean pass to completion.
- Async reset: pulse RST low mid-write between clock edges. Outputs clear immediately, without a clock edge.
- Error saturation and log, PAT_WALK with BIST_ERRLOG_EN defined: FIFO_DOUT stuck at 0 for all 512 reads.
  - ERR_CNT saturates at 8'hFF.
  - ERR_ADDR=0, ERR_EXP=0x01, ERR_ACT=0x00.
